// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-MM initiator port.
//   access_size_t : CPU access width encoding (byte / half / word)
//   avm_state_t   : port FSM states
//   RAM_BASE      : base address of the RAM responder
//   is_legal()    : size/alignment legality check for a CPU access
package avalon_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } avm_state_t;

  localparam logic [31:0] RAM_BASE = 32'hBFC00000;

  // Halves must sit on even addresses, words on 4-byte boundaries;
  // encoding 3 has no width and is always rejected.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~off[0];
      SIZE_WORD: return (off == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/avalon_lane_align.sv
// Purely combinational byte-lane steering.
//   Store path: i_wsize/i_woff/i_wdata -> o_be (byteenable), o_wdata (lane-shifted data)
//   Load path : i_rsize/i_roff/i_rsigned/i_rdata -> o_rdata (extracted, extended)
module avalon_lane_align
  import avalon_pkg::*;
(
  input  logic [1:0]  i_wsize,
  input  logic [1:0]  i_woff,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_rsize,
  input  logic [1:0]  i_roff,
  input  logic        i_rsigned,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_rsh;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    case (i_wsize)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_woff;
        o_wdata = {24'h0, i_wdata[7:0]} << {i_woff, 3'b000};
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_woff;
        o_wdata = {16'h0, i_wdata[15:0]} << {i_woff, 3'b000};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign w_rsh = i_rdata >> {i_roff, 3'b000};

  always_comb begin
    o_rdata = i_rdata;
    case (i_rsize)
      SIZE_BYTE: o_rdata = {{24{i_rsigned & w_rsh[7]}}, w_rsh[7:0]};
      SIZE_HALF: o_rdata = {{16{i_rsigned & w_rsh[15]}}, w_rsh[15:0]};
      default:   o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/avalon_master_port.sv
// Avalon-MM initiator between the CPU load/store stage and the bus.
// One access at a time; FSM IDLE -> ISSUE -> WAIT -> IDLE.
//   CPU side : req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata,
//              rsp_valid/rsp_rdata/rsp_err (one-cycle response pulse)
//   Bus side : address/byteenable/read/write/writedata, waitrequest/readdata
//   clk, reset (synchronous, active-high)
// Optional macro AVM_TIMEOUT_EN: aborts a transfer after TIMEOUT_CYCLES
// stalled WAIT cycles with rsp_err=1.
module avalon_master_port
  import avalon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  avm_state_t  r_state;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_signed;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_accept;
  logic        w_legal;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_legal   = is_legal(req_size, req_addr[1:0]);

  avalon_lane_align u_align (
    .i_wsize   (req_size),
    .i_woff    (req_addr[1:0]),
    .i_wdata   (req_wdata),
    .i_rsize   (r_size),
    .i_roff    (r_off),
    .i_rsigned (r_signed),
    .i_rdata   (readdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

`ifdef AVM_TIMEOUT_EN
  logic [31:0] r_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_size     <= 2'd0;
      r_off      <= 2'd0;
      r_signed   <= 1'b0;
      address    <= 32'h0;
      byteenable <= 4'h0;
      writedata  <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'h0;
`ifdef AVM_TIMEOUT_EN
      r_cnt      <= 32'h0;
`endif
    end else begin
      // Response is a single-cycle pulse unless a branch below raises it.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= w_be;
              writedata  <= req_write ? w_wdata : 32'h0;
              read       <= ~req_write;
              write      <= req_write;
              r_size     <= req_size;
              r_off      <= req_addr[1:0];
              r_signed   <= req_signed;
              r_state    <= ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        // The responder only raises waitrequest a cycle after read/write,
        // so it is meaningless here.
        ISSUE: begin
          r_state <= WAIT;
`ifdef AVM_TIMEOUT_EN
          r_cnt   <= 32'h0;
`endif
        end
        WAIT: begin
          if (!waitrequest) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= write ? 32'h0 : w_rdata;
            r_state   <= IDLE;
          end
`ifdef AVM_TIMEOUT_EN
          else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_port.sv
// Self-checking bench for avalon_master_port: directed cases from the test
// plan plus randomized accesses, checked against a byte-lane reference model.
module tb_avalon_master_port;
  import avalon_pkg::*;

`ifdef AVM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'h0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  avalon_master_port #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: byte counts and shifts straight from the lane rules
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b0;
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] sz);
    return (nbytes(sz) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes(sz))) - 32'd1);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int v;
    v = ((1 << nbytes(sz)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    return (wd & m_mask(sz)) << (8 * (a % 4));
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic sg,
                                       input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int bits;
    if (nbytes(sz) == 4) return rd;
    bits = 8 * nbytes(sz);
    v = (rd >> (8 * (a % 4))) & m_mask(sz);
    if (sg && v[bits-1]) v = v | ~m_mask(sz);
    return v;
  endfunction

  // Drives one access starting at a negedge; returns at the negedge where the
  // response is observed, so the next call makes it a back-to-back request.
  task automatic do_access(input string nm, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int stalls);
    int k;
    int held;
    bit seen;
    chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; readdata = rd; waitrequest = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    if (!m_legal(sz, a)) begin
      chk({nm, ".err_nobus"}, 32'(read | write), 32'd0);
      chk({nm, ".err_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, ".err_flag"}, 32'(rsp_err), 32'd1);
      chk({nm, ".err_rdata"}, rsp_rdata, 32'd0);
      @(negedge clk);
      return;
    end
    chk({nm, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".rd"}, 32'(read), 32'(!wr));
    chk({nm, ".wr"}, 32'(write), 32'(wr));
    chk({nm, ".be"}, 32'(byteenable), 32'(m_be(sz, a)));
    if (wr) chk({nm, ".wdata"}, writedata, m_wd(sz, a, wd));
    k = 0; held = 0; seen = 0;
    while (k < 60) begin
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      if (read | write) begin
        held++;
        chk({nm, ".addr_hold"}, address, {a[31:2], 2'b00});
      end
      waitrequest = (k + 1 >= 1) && (k + 1 <= 1 + stalls) && (stalls > 0);
      @(negedge clk);
      k++;
    end
    waitrequest = 1'b0;
    chk({nm, ".seen"}, 32'(seen), 32'd1);
    chk({nm, ".latency"}, 32'(k + 1), 32'(3 + stalls));
    chk({nm, ".held"}, 32'(held), 32'(2 + stalls));
    chk({nm, ".rsp_err"}, 32'(rsp_err), 32'd0);
    chk({nm, ".rsp_rdata"}, rsp_rdata, wr ? 32'd0 : m_rd(sz, sg, a, rd));
    chk({nm, ".bus_idle"}, 32'(read | write), 32'd0);
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int k;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.read", 32'(read), 32'd0);
    chk("rst.write", 32'(write), 32'd0);
    chk("rst.address", address, 32'd0);
    chk("rst.be", 32'(byteenable), 32'd0);
    chk("rst.wdata", writedata, 32'd0);
    chk("rst.rsp", {29'd0, rsp_valid, rsp_err, 1'b0}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // test plan
    do_access("wload", 1'b0, 2'd2, 1'b0, RAM_BASE + 32'h4, 32'h0, 32'hDEADBEEF, 4);
    do_access("sbyte", 1'b0, 2'd0, 1'b1, RAM_BASE + 32'h3, 32'h0, 32'h80FF0000, 1);
    do_access("ubyte", 1'b0, 2'd0, 1'b0, RAM_BASE + 32'h3, 32'h0, 32'h80FF0000, 0);
    do_access("hstore", 1'b1, 2'd1, 1'b0, RAM_BASE + 32'h2, 32'h1234ABCD, 32'h0, 3);
    do_access("misal", 1'b0, 2'd2, 1'b0, RAM_BASE + 32'h1, 32'h0, 32'h0, 0);
    do_access("size3", 1'b1, 2'd3, 1'b0, RAM_BASE, 32'h55, 32'h0, 0);
    do_access("shalf", 1'b0, 2'd1, 1'b1, RAM_BASE + 32'h2, 32'h0, 32'h8001_1234, 2);

    // randomized accesses, roughly three quarters legal
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = RAM_BASE + {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3)) & ~2'(nbytes(sz == 2'd3 ? 2'd2 : sz) - 1);
      else a[1:0] = 2'($urandom_range(0, 3));
      do_access("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 5));
    end
    @(negedge clk);

    // reset while stalled in WAIT
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = RAM_BASE;
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstw.read_before", 32'(read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    chk("rstw.read", 32'(read), 32'd0);
    chk("rstw.valid", 32'(rsp_valid), 32'd0);
    chk("rstw.ready", 32'(req_ready), 32'd1);
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    chk("rstw.no_rsp", 32'(k), 32'd0);

`ifdef AVM_TIMEOUT_EN
    // stuck responder
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = RAM_BASE + 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = 1'b1;
    k = 0;
    while (!rsp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("to.cycle", 32'(k), 32'(TO + 1));
    chk("to.err", 32'(rsp_err), 32'd1);
    chk("to.rdata", rsp_rdata, 32'd0);
    chk("to.read", 32'(read), 32'd0);
    waitrequest = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/avalon_master_port.md
Name: avalon_master_port

Overview:
- Avalon-MM initiator. Sits between the CPU load/store stage and the memory-mapped bus. The bus responder is the RAM model, which supports byteenable and variable waitrequest stalls.
- Accepts one CPU access at a time: byte, half or word, read or write.
- Drives one Avalon transfer per access and holds it stable while the responder stalls.
- Aligns data into byte lanes and returns a one-cycle response pulse with read data. Loads are zero- or sign-extended.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT-state cycles before abort. Used only with AVM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  port idle, can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_signed  in  1  sign-extend loaded byte/half
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal size, or timeout
- address  out  32  word-aligned address, bits [1:0] = 00
- byteenable  out  4  active lanes
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  32  lane-shifted store data
- waitrequest  in  1  responder stall
- readdata  in  32  responder data

Behaviour:
- Reset values: read=0, write=0, address=0, byteenable=0, writedata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. State=IDLE, so req_ready=1.
- Reset mid-transfer: read/write drop at the reset edge, no rsp_valid is produced, and the access is lost.
- req_ready=1 only in IDLE. A request is accepted on an edge with req_valid & req_ready.
- Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; size 3 is always illegal.
- Illegal access: no bus cycle. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; state stays IDLE.
- Legal access, lane mapping, with o = addr[1:0]:
  - byteenable: byte = 0001<<o; half = 0011<<o; word = 1111.
  - writedata = req_wdata << (8*o), taking low byte/half for narrow sizes; unused lanes are 0.
- State machine, IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: on a legal accept, register address/byteenable/writedata and raise read or write; go to ISSUE.
  - ISSUE: exactly one cycle. waitrequest is NOT sampled here, because the responder raises waitrequest one cycle after read/write rise. Go to WAIT.
  - WAIT: hold address, byteenable, writedata and read/write stable while waitrequest=1.
  - WAIT completion: on the first edge with waitrequest=0, capture readdata, drop read/write, pulse rsp_valid next cycle with rsp_err=0, and go to IDLE.
- Load extraction: take the byte/half at lane o from readdata.
  - req_signed=1: sign-extend from bit 7 or bit 15.
  - req_signed=0: zero-extend.
  - word: pass through unchanged.
- Minimum latency: accept edge to rsp_valid is 3 cycles; each extra stall cycle adds 1.
- Back-to-back requests: a new request is accepted on the edge where rsp_valid is high. read/write are therefore low for at least one cycle between transfers.
- Inputs req_* are ignored outside IDLE.

Optional Feature:
- Macro: AVM_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT, incremented each WAIT cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: drop read/write, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, go to IDLE.
  - A completion and the timeout on the same edge: completion wins.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Shared package avalon_pkg:
  - access_size_t enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - avm_state_t enum: IDLE, ISSUE, WAIT.
  - Constant RAM_BASE = 32'hBFC00000.
- Sub-module avalon_lane_align, purely combinational:
  - Maps size/offset/wdata to byteenable/writedata.
  - Maps size/offset/signed/readdata to rsp_rdata.

Test Plan:
- Word load from 0xBFC00004; responder stalls 4 cycles and returns 0xDEADBEEF -> byteenable=1111, read held 6 cycles, rsp_rdata=0xDEADBEEF 7 cycles after accept.
- Signed byte load from 0xBFC00003, readdata=0x80FF0000 -> byteenable=1000, rsp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0x1234ABCD to 0xBFC00002 -> address=0xBFC00000, byteenable=1100, writedata=0xABCD0000, write held until waitrequest=0.
- Word load from 0xBFC00001 -> no read asserted, rsp_valid=1 with rsp_err=1 one cycle after accept.
- Reset asserted in WAIT -> read=0 next cycle, no rsp_valid, req_ready=1.
- AVM_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> rsp_err=1 after 8 WAIT cycles, read=0.
